pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It generates the per-register write enables and flush strobes for IF/ID, ID/EX, EX/MEM and MEM/WB, and it selects the PC source. It detects load-use hazards between ID and EX, redirects on taken branch/jump resolved in MEM, and freezes the pipeline while a multi-cycle data memory completes an access. It sits beside the pipeline registers and consumes their control outputs; it holds no datapath state.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/load_use_detect.sv | 15 +
 rtl/pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states and PC source encodings.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_src_e;

    // Jump outranks a taken branch when both resolve in MEM together.
    function automatic pc_src_e redirect_sel(input logic jump, input logic branch_taken);
        if (jump)              return PC_JUMP;
        else if (branch_taken) return PC_BRANCH;
        else                   return PC_SEQ;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID-stage instruction that reads the destination of a load sitting in EX.
module load_use_detect (
    input  logic       ex_MemRead,
    input  logic [4:0] ex_reg_des_address,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign hazard = ex_MemRead
                  && (ex_reg_des_address != 5'd0)
                  && ((ex_reg_des_address == id_rs) || (ex_reg_des_address == id_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use stalls, MEM-stage
// redirects and freezing for a multi-cycle data memory, with a timeout error state.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_reg_des_address,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_jump,
    input  logic             mem_MemRead,
    input  logic             mem_MemWrite,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       pc_src,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned WAIT_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

    state_e            state;
    state_e            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              mem_op;
    logic              branch_taken;
    logic              redirect;
    logic              hazard;
    logic              run_eval;

    assign mem_op       = mem_MemRead | mem_MemWrite;
    assign branch_taken = mem_branch & mem_zero;
    assign redirect     = branch_taken | mem_jump;
    assign mem_err      = (state == ERR);

    load_use_detect u_load_use_detect (
        .ex_MemRead         (ex_MemRead),
        .ex_reg_des_address (ex_reg_des_address),
        .id_rs              (id_rs),
        .id_rt              (id_rt),
        .hazard             (hazard)
    );

    // State and wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Next state and zero-cycle stall/flush decisions
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_src       = PC_SEQ;
        dmem_req     = 1'b0;
        state_next   = state;
        wait_next    = wait_cnt;
        run_eval     = 1'b0;

        case (state)
            RUN: begin
                dmem_req = mem_op;
                if (mem_op && !dmem_ready) state_next = MEM_WAIT;
                else                       run_eval   = 1'b1;
            end
            MEM_WAIT: begin
                dmem_req = mem_op;
                if (!dmem_ready) begin
                    wait_next = wait_cnt + WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(WAIT_MAX - 2)) state_next = ERR;
                end else begin
                    run_eval   = 1'b1;
                    wait_next  = '0;
                    state_next = RUN;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = RUN;
            end
        endcase

        // A redirect squashes the younger instructions, so any load-use among them is moot.
        if (run_eval) begin
            if (redirect) begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                id_ex_en     = 1'b1;
                ex_mem_en    = 1'b1;
                mem_wb_en    = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                pc_src       = redirect_sel(mem_jump, branch_taken);
            end else if (hazard) begin
                id_ex_en     = 1'b1;
                ex_mem_en    = 1'b1;
                mem_wb_en    = 1'b1;
                id_ex_flush  = 1'b1;
            end else begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                id_ex_en     = 1'b1;
                ex_mem_en    = 1'b1;
                mem_wb_en    = 1'b1;
            end
        end

        // Held in reset: the pipeline is frozen and any memory access is abandoned.
        if (!reset_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            pc_src       = PC_SEQ;
            dmem_req     = 1'b0;
        end
    end

    // Saturating count of frozen-PC cycles; the error state is not counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (!pc_en && (state != ERR) && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (WAIT_MAX=4 so the timeout is reachable quickly).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned CNT_W    = 16;

    // Packed control view: {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,
    //                       if_id_flush,id_ex_flush,ex_mem_flush,pc_src[1:0],dmem_req,mem_err}
    localparam logic [11:0] C_IDLE   = 12'h000;
    localparam logic [11:0] C_RUN    = 12'hF80;
    localparam logic [11:0] C_RUNREQ = 12'hF82;
    localparam logic [11:0] C_LDUSE  = 12'h3A0;
    localparam logic [11:0] C_BR     = 12'hFF4;
    localparam logic [11:0] C_JMP    = 12'hFF8;
    localparam logic [11:0] C_JMPREQ = 12'hFFA;
    localparam logic [11:0] C_MSTALL = 12'h002;
    localparam logic [11:0] C_ERR    = 12'h001;

    logic             clk;
    logic             reset_n;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_MemRead;
    logic [4:0]       ex_reg_des_address;
    logic             mem_branch;
    logic             mem_zero;
    logic             mem_jump;
    logic             mem_MemRead;
    logic             mem_MemWrite;
    logic             dmem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic [1:0]       pc_src;
    logic             dmem_req;
    logic             mem_err;
    logic [CNT_W-1:0] stall_count;
    logic [11:0]      ctl;

    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .id_rs              (id_rs),
        .id_rt              (id_rt),
        .ex_MemRead         (ex_MemRead),
        .ex_reg_des_address (ex_reg_des_address),
        .mem_branch         (mem_branch),
        .mem_zero           (mem_zero),
        .mem_jump           (mem_jump),
        .mem_MemRead        (mem_MemRead),
        .mem_MemWrite       (mem_MemWrite),
        .dmem_ready         (dmem_ready),
        .pc_en              (pc_en),
        .if_id_en           (if_id_en),
        .id_ex_en           (id_ex_en),
        .ex_mem_en          (ex_mem_en),
        .mem_wb_en          (mem_wb_en),
        .if_id_flush        (if_id_flush),
        .id_ex_flush        (id_ex_flush),
        .ex_mem_flush       (ex_mem_flush),
        .pc_src             (pc_src),
        .dmem_req           (dmem_req),
        .mem_err            (mem_err),
        .stall_count        (stall_count)
    );

    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, ex_mem_flush, pc_src, dmem_req, mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs              = 5'd0;
        id_rt              = 5'd0;
        ex_MemRead         = 1'b0;
        ex_reg_des_address = 5'd0;
        mem_branch         = 1'b0;
        mem_zero           = 1'b0;
        mem_jump           = 1'b0;
        mem_MemRead        = 1'b0;
        mem_MemWrite       = 1'b0;
        dmem_ready         = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        #2;
        check("reset_ctl", 32'(ctl), 32'(C_IDLE));
        check("reset_sc", 32'(stall_count), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        check("idle_run", 32'(ctl), 32'(C_RUN));
        tick();

        // Load-use on rs
        ex_MemRead = 1'b1; ex_reg_des_address = 5'd8; id_rs = 5'd8;
        #1 check("ldu_rs", 32'(ctl), 32'(C_LDUSE));
        tick();
        clear_inputs();
        #1 check("ldu_after", 32'(ctl), 32'(C_RUN));
        check("ldu_sc", 32'(stall_count), 32'd1);

        // Load to r0 never stalls
        ex_MemRead = 1'b1; ex_reg_des_address = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1 check("ldu_r0", 32'(ctl), 32'(C_RUN));
        tick();
        check("ldu_r0_sc", 32'(stall_count), 32'd1);

        // Load-use on rt
        ex_reg_des_address = 5'd5; id_rs = 5'd3; id_rt = 5'd5;
        #1 check("ldu_rt", 32'(ctl), 32'(C_LDUSE));
        tick();
        check("ldu_rt_sc", 32'(stall_count), 32'd2);

        // Taken branch with coincident load-use
        mem_branch = 1'b1; mem_zero = 1'b1;
        #1 check("br_taken", 32'(ctl), 32'(C_BR));
        tick();
        check("br_sc", 32'(stall_count), 32'd2);
        clear_inputs();
        mem_branch = 1'b1;
        #1 check("br_not_taken", 32'(ctl), 32'(C_RUN));
        tick();

        // Jump with coincident load-use
        ex_MemRead = 1'b1; ex_reg_des_address = 5'd9; id_rs = 5'd9; mem_jump = 1'b1;
        #1 check("jump", 32'(ctl), 32'(C_JMP));
        tick();
        check("jump_sc", 32'(stall_count), 32'd2);
        clear_inputs();

        // Memory wait: ready low for 3 cycles, then high
        mem_MemRead = 1'b1;
        #1 check("mw_run", 32'(ctl), 32'(C_MSTALL));
        tick();
        check("mw_wait1", 32'(ctl), 32'(C_MSTALL));
        tick();
        check("mw_wait2", 32'(ctl), 32'(C_MSTALL));
        tick();
        dmem_ready = 1'b1;
        #1 check("mw_done", 32'(ctl), 32'(C_RUNREQ));
        tick();
        check("mw_sc", 32'(stall_count), 32'd5);
        clear_inputs();
        #1 check("mw_back_run", 32'(ctl), 32'(C_RUN));
        tick();

        // Wait ends while a jump is pending in MEM
        mem_MemWrite = 1'b1;
        #1 check("mwj_run", 32'(ctl), 32'(C_MSTALL));
        tick();
        mem_jump = 1'b1; dmem_ready = 1'b1;
        #1 check("mwj_done", 32'(ctl), 32'(C_JMPREQ));
        tick();
        check("mwj_sc", 32'(stall_count), 32'd6);
        clear_inputs();

        // Ready in the same cycle as the op costs nothing; stray ready is ignored
        mem_MemRead = 1'b1; dmem_ready = 1'b1;
        #1 check("mem_zero_wait", 32'(ctl), 32'(C_RUNREQ));
        tick();
        mem_MemRead = 1'b0;
        #1 check("stray_ready", 32'(ctl), 32'(C_RUN));
        tick();
        check("zero_wait_sc", 32'(stall_count), 32'd6);
        clear_inputs();

        // Timeout: four stalled cycles, then ERR
        mem_MemWrite = 1'b1;
        #1 check("to_run", 32'(ctl), 32'(C_MSTALL));
        tick();
        check("to_w0", 32'(ctl), 32'(C_MSTALL));
        tick();
        check("to_w1", 32'(ctl), 32'(C_MSTALL));
        tick();
        check("to_w2", 32'(ctl), 32'(C_MSTALL));
        tick();
        check("to_err", 32'(ctl), 32'(C_ERR));
        check("to_sc", 32'(stall_count), 32'd10);
        mem_jump = 1'b1; dmem_ready = 1'b1;
        tick();
        check("err_sticky", 32'(ctl), 32'(C_ERR));
        check("err_no_count", 32'(stall_count), 32'd10);

        // Reset is the only way out of ERR
        #1 reset_n = 1'b0;
        #1 check("err_reset_ctl", 32'(ctl), 32'(C_IDLE));
        check("err_reset_sc", 32'(stall_count), 32'd0);
        clear_inputs();
        #1 reset_n = 1'b1;
        tick();
        check("post_err_run", 32'(ctl), 32'(C_RUN));

        // Asynchronous reset in the middle of a memory wait
        mem_MemRead = 1'b1;
        #1 check("arst_run", 32'(ctl), 32'(C_MSTALL));
        tick();
        check("arst_wait", 32'(ctl), 32'(C_MSTALL));
        check("arst_wait_sc", 32'(stall_count), 32'd1);
        #1 reset_n = 1'b0;
        #1 check("arst_ctl", 32'(ctl), 32'(C_IDLE));
        check("arst_sc", 32'(stall_count), 32'd0);
        #1 reset_n = 1'b1;
        clear_inputs();
        tick();
        check("arst_after", 32'(ctl), 32'(C_RUN));
        check("arst_after_sc", 32'(stall_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
